// File: rtl/pipe_pkg.sv
// Shared pipeline types: ID/EX control bundle, its NOP encoding and the stall-watchdog states.
package pipe_pkg;

  localparam int ALUOP_W = 4;
  localparam logic [ALUOP_W-1:0] ALUOP_NOP = 4'd0;

  typedef struct packed {
    logic               regwrite;
    logic [4:0]         wbregnum;
    logic               hiwrite;
    logic               lowrite;
    logic               memread;
    logic               memwrite;
    logic [ALUOP_W-1:0] aluop;
  } idex_ctrl_t;

  localparam idex_ctrl_t IDEX_NOP = '{
    regwrite: 1'b0,
    wbregnum: 5'd0,
    hiwrite:  1'b0,
    lowrite:  1'b0,
    memread:  1'b0,
    memwrite: 1'b0,
    aluop:    ALUOP_NOP
  };

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HUNG  = 2'd2
  } stall_st_t;

endpackage

// File: rtl/stall_watchdog.sv
// Observes bubble cycles: saturating bubble count plus a sticky flag when a stall
// lasts MAX_STALL consecutive cycles. Has no effect on pipeline control.
module stall_watchdog
  import pipe_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_err
);

  localparam int CONS_W = $clog2(MAX_STALL) + 1;
  localparam logic [CONS_W-1:0] CONS_LAST = CONS_W'(MAX_STALL - 1);

  stall_st_t          state_r;
  logic [CONS_W-1:0]  consec_r;
  logic [CNT_W-1:0]   stall_cnt_r;
  logic               stall_err_r;

  // Stall FSM with consecutive-bubble counter; HUNG is absorbing until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      consec_r    <= {CONS_W{1'b0}};
      stall_err_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (bubble) begin
            state_r  <= STALL;
            consec_r <= CONS_W'(1);
          end else begin
            consec_r <= {CONS_W{1'b0}};
          end
        end
        STALL: begin
          if (bubble) begin
            if (consec_r == CONS_LAST) begin
              state_r     <= HUNG;
              stall_err_r <= 1'b1;
            end else begin
              consec_r <= consec_r + CONS_W'(1);
            end
          end else begin
            state_r  <= RUN;
            consec_r <= {CONS_W{1'b0}};
          end
        end
        HUNG: begin
          state_r <= HUNG;
        end
        default: begin
          state_r  <= RUN;
          consec_r <= {CONS_W{1'b0}};
        end
      endcase
    end
  end

  // Saturating count of every bubble cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (bubble && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign stall_err = stall_err_r;

endmodule

// File: rtl/id_ex_stall_reg.sv
// ID/EX pipeline register: freezes PC and IF/ID on a data hazard and injects a NOP
// into EX; flush kills the ID instruction. Write controls feed back to the hazard detector.
module id_ex_stall_reg
  import pipe_pkg::*;
#(
  parameter int ALUOP_W   = 4,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bb_data,
  input  logic               flush,
  input  logic               id_valid,
  input  logic               regwrite_id,
  input  logic [4:0]         wbregnum_id,
  input  logic               hiwrite_id,
  input  logic               lowrite_id,
  input  logic               memread_id,
  input  logic               memwrite_id,
  input  logic [ALUOP_W-1:0] aluop_id,
  input  logic [31:0]        pc_id,
  input  logic [31:0]        rs_val_id,
  input  logic [31:0]        rt_val_id,
  input  logic [31:0]        imm_id,
  output logic               pc_we,
  output logic               ifid_we,
  output logic               ex_valid,
  output logic               regwrite_ex,
  output logic [4:0]         wbregnum_ex,
  output logic               hiwrite_ex,
  output logic               lowrite_ex,
  output logic               memread_ex,
  output logic               memwrite_ex,
  output logic [ALUOP_W-1:0] aluop_ex,
  output logic [31:0]        pc_ex,
  output logic [31:0]        rs_val_ex,
  output logic [31:0]        rt_val_ex,
  output logic [31:0]        imm_ex,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic               stall_err
);

  logic       bubble_s;
  logic       kill_s;
  idex_ctrl_t adv_ctrl_s;
  idex_ctrl_t ctrl_r;
  logic       ex_valid_r;
  logic [31:0] pc_r, rs_val_r, rt_val_r, imm_r;

  // flush outranks the hazard, so a killed instruction never counts as a stall.
  assign bubble_s = bb_data & id_valid & ~flush;
  assign kill_s   = flush;
  assign pc_we    = ~bubble_s;
  assign ifid_we  = ~bubble_s;

  // Control bundle for a normal advance; r0 writes are dropped so the detector never stalls on $zero.
  always_comb begin
    adv_ctrl_s          = IDEX_NOP;
    adv_ctrl_s.regwrite = regwrite_id & id_valid & (wbregnum_id != 5'd0);
    adv_ctrl_s.wbregnum = wbregnum_id;
    adv_ctrl_s.hiwrite  = hiwrite_id & id_valid;
    adv_ctrl_s.lowrite  = lowrite_id & id_valid;
    adv_ctrl_s.memread  = memread_id & id_valid;
    adv_ctrl_s.memwrite = memwrite_id & id_valid;
    adv_ctrl_s.aluop    = aluop_id[ALUOP_W-1:0];
  end

  // ID/EX register: kill or bubble loads a NOP and leaves operands untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_r     <= IDEX_NOP;
      ex_valid_r <= 1'b0;
      pc_r       <= 32'd0;
      rs_val_r   <= 32'd0;
      rt_val_r   <= 32'd0;
      imm_r      <= 32'd0;
    end else if (kill_s || bubble_s) begin
      ctrl_r     <= IDEX_NOP;
      ex_valid_r <= 1'b0;
    end else begin
      ctrl_r     <= adv_ctrl_s;
      ex_valid_r <= id_valid;
      pc_r       <= pc_id;
      rs_val_r   <= rs_val_id;
      rt_val_r   <= rt_val_id;
      imm_r      <= imm_id;
    end
  end

  assign ex_valid    = ex_valid_r;
  assign regwrite_ex = ctrl_r.regwrite;
  assign wbregnum_ex = ctrl_r.wbregnum;
  assign hiwrite_ex  = ctrl_r.hiwrite;
  assign lowrite_ex  = ctrl_r.lowrite;
  assign memread_ex  = ctrl_r.memread;
  assign memwrite_ex = ctrl_r.memwrite;
  assign aluop_ex    = ctrl_r.aluop;
  assign pc_ex       = pc_r;
  assign rs_val_ex   = rs_val_r;
  assign rt_val_ex   = rt_val_r;
  assign imm_ex      = imm_r;

  stall_watchdog #(
    .CNT_W     (CNT_W),
    .MAX_STALL (MAX_STALL)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .bubble    (bubble_s),
    .stall_cnt (stall_cnt),
    .stall_err (stall_err)
  );

endmodule

// File: tb/tb_id_ex_stall_reg.sv
// Directed bench for id_ex_stall_reg: advance, bubble, flush priority, $zero rule,
// watchdog threshold and asynchronous reset, with hand-computed expectations.
module tb_id_ex_stall_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        bb_data, flush, id_valid;
  logic        regwrite_id, hiwrite_id, lowrite_id, memread_id, memwrite_id;
  logic [4:0]  wbregnum_id;
  logic [3:0]  aluop_id;
  logic [31:0] pc_id, rs_val_id, rt_val_id, imm_id;
  logic        pc_we, ifid_we, ex_valid;
  logic        regwrite_ex, hiwrite_ex, lowrite_ex, memread_ex, memwrite_ex;
  logic [4:0]  wbregnum_ex;
  logic [3:0]  aluop_ex;
  logic [31:0] pc_ex, rs_val_ex, rt_val_ex, imm_ex;
  logic [15:0] stall_cnt;
  logic        stall_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  id_ex_stall_reg #(.ALUOP_W(4), .CNT_W(16), .MAX_STALL(4)) u_dut (
    .clk(clk), .rst(rst), .bb_data(bb_data), .flush(flush), .id_valid(id_valid),
    .regwrite_id(regwrite_id), .wbregnum_id(wbregnum_id), .hiwrite_id(hiwrite_id),
    .lowrite_id(lowrite_id), .memread_id(memread_id), .memwrite_id(memwrite_id),
    .aluop_id(aluop_id), .pc_id(pc_id), .rs_val_id(rs_val_id), .rt_val_id(rt_val_id),
    .imm_id(imm_id), .pc_we(pc_we), .ifid_we(ifid_we), .ex_valid(ex_valid),
    .regwrite_ex(regwrite_ex), .wbregnum_ex(wbregnum_ex), .hiwrite_ex(hiwrite_ex),
    .lowrite_ex(lowrite_ex), .memread_ex(memread_ex), .memwrite_ex(memwrite_ex),
    .aluop_ex(aluop_ex), .pc_ex(pc_ex), .rs_val_ex(rs_val_ex), .rt_val_ex(rt_val_ex),
    .imm_ex(imm_ex), .stall_cnt(stall_cnt), .stall_err(stall_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 2ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_id(input logic v, input logic rw, input logic [4:0] wb,
                        input logic [3:0] op, input logic [31:0] pc);
    id_valid = v; regwrite_id = rw; wbregnum_id = wb; aluop_id = op; pc_id = pc;
    rs_val_id = pc ^ 32'h1111_0000; rt_val_id = pc + 32'd7; imm_id = {16'd0, pc[15:0]};
  endtask

  initial begin
    rst = 1'b1; bb_data = 1'b0; flush = 1'b0;
    hiwrite_id = 1'b0; lowrite_id = 1'b0; memread_id = 1'b0; memwrite_id = 1'b0;
    set_id(1'b0, 1'b0, 5'd0, 4'd0, 32'd0);
    #12;
    rst = 1'b0;
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("rst_stall_err", {31'd0, stall_err}, 32'd0);

    // Advance
    set_id(1'b1, 1'b1, 5'd5, 4'd3, 32'h0000_0100);
    #1 check("adv_pc_we", {31'd0, pc_we}, 32'd1);
    tick();
    check("adv_ex_valid", {31'd0, ex_valid}, 32'd1);
    check("adv_wbregnum", {27'd0, wbregnum_ex}, 32'd5);
    check("adv_regwrite", {31'd0, regwrite_ex}, 32'd1);
    check("adv_aluop", {28'd0, aluop_ex}, 32'd3);
    check("adv_pc_ex", pc_ex, 32'h0000_0100);
    check("adv_rt_val", rt_val_ex, 32'h0000_0107);

    // Single bubble on a dependent add
    set_id(1'b1, 1'b1, 5'd7, 4'd2, 32'h0000_0104);
    bb_data = 1'b1;
    #1 check("bub_pc_we", {31'd0, pc_we}, 32'd0);
    check("bub_ifid_we", {31'd0, ifid_we}, 32'd0);
    tick();
    check("bub_regwrite", {31'd0, regwrite_ex}, 32'd0);
    check("bub_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("bub_wbregnum", {27'd0, wbregnum_ex}, 32'd0);
    check("bub_pc_hold", pc_ex, 32'h0000_0100);
    check("bub_cnt", {16'd0, stall_cnt}, 32'd1);
    bb_data = 1'b0;
    #1 check("bub_release_pc_we", {31'd0, pc_we}, 32'd1);
    tick();
    check("issue_ex_valid", {31'd0, ex_valid}, 32'd1);
    check("issue_wbregnum", {27'd0, wbregnum_ex}, 32'd7);
    check("issue_pc_ex", pc_ex, 32'h0000_0104);

    // Flush together with a stall request
    set_id(1'b1, 1'b1, 5'd8, 4'd1, 32'h0000_0108);
    bb_data = 1'b1; flush = 1'b1;
    #1 check("flush_pc_we", {31'd0, pc_we}, 32'd1);
    tick();
    check("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("flush_regwrite", {31'd0, regwrite_ex}, 32'd0);
    check("flush_pc_hold", pc_ex, 32'h0000_0104);
    check("flush_cnt", {16'd0, stall_cnt}, 32'd1);
    check("flush_fsm_run", {30'd0, u_dut.u_watchdog.state_r}, 32'd0);
    bb_data = 1'b0; flush = 1'b0;

    // $zero destination
    set_id(1'b1, 1'b1, 5'd0, 4'd4, 32'h0000_010C);
    tick();
    check("zero_regwrite", {31'd0, regwrite_ex}, 32'd0);
    check("zero_ex_valid", {31'd0, ex_valid}, 32'd1);

    // Invalid ID: enables masked
    set_id(1'b0, 1'b1, 5'd3, 4'd4, 32'h0000_0110);
    hiwrite_id = 1'b1; memwrite_id = 1'b1;
    tick();
    check("inv_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("inv_memwrite", {31'd0, memwrite_ex}, 32'd0);
    check("inv_hiwrite", {31'd0, hiwrite_ex}, 32'd0);
    hiwrite_id = 1'b0; memwrite_id = 1'b0;

    // Three-cycle stall stays below the watchdog threshold
    set_id(1'b1, 1'b1, 5'd9, 4'd5, 32'h0000_0114);
    bb_data = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bb_data = 1'b0;
    tick();
    check("wd3_err", {31'd0, stall_err}, 32'd0);
    check("wd3_cnt", {16'd0, stall_cnt}, 32'd4);

    // Four-cycle stall trips the watchdog on the fourth edge
    set_id(1'b1, 1'b1, 5'd10, 4'd6, 32'h0000_0118);
    bb_data = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("wd4_err_pre", {31'd0, stall_err}, 32'd0);
    tick();
    check("wd4_err", {31'd0, stall_err}, 32'd1);
    bb_data = 1'b0;
    tick();
    check("wd4_err_sticky", {31'd0, stall_err}, 32'd1);
    check("wd4_cnt", {16'd0, stall_cnt}, 32'd8);
    check("wd4_issue_wb", {27'd0, wbregnum_ex}, 32'd10);
    check("wd4_issue_rw", {31'd0, regwrite_ex}, 32'd1);

    // Asynchronous reset between edges while stalling
    bb_data = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("arst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("arst_wbregnum", {27'd0, wbregnum_ex}, 32'd0);
    check("arst_pc_ex", pc_ex, 32'd0);
    check("arst_cnt", {16'd0, stall_cnt}, 32'd0);
    check("arst_err", {31'd0, stall_err}, 32'd0);
    check("arst_pc_we", {31'd0, pc_we}, 32'd0);
    bb_data = 1'b0;
    #1 check("arst_pc_we_follow", {31'd0, pc_we}, 32'd1);
    rst = 1'b0;
    tick();
    check("post_rst_cnt", {16'd0, stall_cnt}, 32'd0);
    check("post_rst_ex_valid", {31'd0, ex_valid}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
